leaf_packetizer: RTL and testbench

Transmit-side leaf adapter that turns a user kernel's 32-bit valid/ack output stream into 49-bit BFT packets. It stamps destination/source routing fields, enforces credit-based flow control against the destination leaf's input BRAM, and replays the last packet on request. It sits between an HLS kernel's `Output_*_V` stream and the leaf's `dout_leaf_interface2bft` injection point.

---
 rtl/leaf_packetizer.sv | 129 ++++++++++++
 tb/tb_leaf_packetizer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_packetizer.sv
// Transmit-side leaf adapter: 32-bit valid/ack stream -> 49-bit BFT packets with
// credit flow control and last-packet replay. Optional counters: LEAF_PACKETIZER_STATS_EN.
module leaf_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 4,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int SRC_LEAF              = 0,
    parameter int SRC_PORT              = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
    input  logic                     vld_user2interface,
    output logic                     ack_interface2user,
    input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
    input  logic [NUM_PORT_BITS-1:0] dst_port,
    input  logic                     freespace_update,
    input  logic                     ready_bft2interface,
    input  logic                     resend,
    output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft
`ifdef LEAF_PACKETIZER_STATS_EN
    ,
    output logic [31:0]              pkt_count,
    output logic [15:0]              resend_count
`endif
);

    localparam int WORD_BITS   = NUM_LEAF_BITS + NUM_PORT_BITS + PAYLOAD_BITS;
    localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
    localparam logic [CREDIT_BITS:0] CREDIT_MAX  = (CREDIT_BITS+1)'(2 ** NUM_BRAM_ADDR_BITS);
    localparam logic [CREDIT_BITS:0] CREDIT_STEP = (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE);
    localparam logic [NUM_LEAF_BITS-1:0] SRC_LEAF_F = NUM_LEAF_BITS'(SRC_LEAF);
    localparam logic [NUM_PORT_BITS-1:0] SRC_PORT_F = NUM_PORT_BITS'(SRC_PORT);

    typedef enum logic [1:0] {IDLE, SEND, CREDIT_WAIT, RESEND} state_t;

    state_t                 state, state_next;
    logic [WORD_BITS-1:0]   fifo_mem [2];
    logic                   wr_ptr, rd_ptr;
    logic [1:0]             count, count_next;
    logic [CREDIT_BITS-1:0] credit, credit_next;
    logic [CREDIT_BITS:0]   credit_sum;
    logic [PACKET_BITS-1:0] last_pkt, head_pkt;
    logic [WORD_BITS-1:0]   head;
    logic                   last_valid;
    logic                   push, new_issue, replay, pending, pending_next, resend_ok;

    assign ack_interface2user = !reset && (count != 2'd2);
    assign push     = vld_user2interface && ack_interface2user;
    assign head     = fifo_mem[rd_ptr];
    assign head_pkt = {1'b1, head[WORD_BITS-1:PAYLOAD_BITS], SRC_LEAF_F, SRC_PORT_F,
                       head[PAYLOAD_BITS-1:0]};

    // The pending-replay flag lives in the state itself: RESEND <=> replay owed.
    always_comb begin
        pending    = (state == RESEND);
        replay     = pending && ready_bft2interface;
        new_issue  = (state == SEND) && ready_bft2interface;
        count_next = count + {1'b0, push} - {1'b0, new_issue};
        credit_sum = {1'b0, credit} + (freespace_update ? CREDIT_STEP : '0)
                     - (CREDIT_BITS+1)'(new_issue);
        credit_next = (credit_sum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_BITS-1:0]
                                                : credit_sum[CREDIT_BITS-1:0];
        resend_ok    = resend && (last_valid || new_issue);
        pending_next = (pending && !replay) || (resend_ok && !pending);
        state_next   = IDLE;
        if (pending_next)
            state_next = RESEND;
        else if (count_next == 2'd0)
            state_next = IDLE;
        else if (credit_next != '0)
            state_next = SEND;
        else
            state_next = CREDIT_WAIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            credit     <= CREDIT_MAX[CREDIT_BITS-1:0];
            last_valid <= 1'b0;
            dout_leaf_interface2bft <= '0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            credit <= credit_next;
            if (push)
                wr_ptr <= ~wr_ptr;
            if (new_issue) begin
                rd_ptr     <= ~rd_ptr;
                last_valid <= 1'b1;
            end
            if (new_issue)
                dout_leaf_interface2bft <= head_pkt;
            else if (replay)
                dout_leaf_interface2bft <= last_pkt;
            else
                dout_leaf_interface2bft <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {dst_leaf, dst_port, din_leaf_user2interface};
        if (new_issue)
            last_pkt <= head_pkt;
    end

`ifdef LEAF_PACKETIZER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count    <= '0;
            resend_count <= '0;
        end else begin
            if (new_issue)
                pkt_count <= pkt_count + 32'd1;
            if (replay)
                resend_count <= resend_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_leaf_packetizer.sv
// Self-checking bench for leaf_packetizer: randomized streams against a
// queue-based packet model plus directed credit, stall, replay and reset scenarios.
module tb_leaf_packetizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        vld;
    logic        ack;
    logic [3:0]  dst_leaf, dst_port;
    logic        fsu;
    logic        ready;
    logic        resend;
    logic [48:0] dout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nz_idle = 0;

    logic [48:0] acc_q[$];
    int          acc_cyc[$];
    logic [48:0] got_q[$];
    int          got_cyc[$];
    bit          rdy_hist [4096];

    leaf_packetizer #(
        .PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(4), .NUM_PORT_BITS(4),
        .NUM_BRAM_ADDR_BITS(7), .FREESPACE_UPDATE_SIZE(64), .SRC_LEAF(5), .SRC_PORT(0)
    ) dut (
        .clk(clk), .reset(reset),
        .din_leaf_user2interface(din), .vld_user2interface(vld), .ack_interface2user(ack),
        .dst_leaf(dst_leaf), .dst_port(dst_port), .freespace_update(fsu),
        .ready_bft2interface(ready), .resend(resend), .dout_leaf_interface2bft(dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Packet format built straight from the field layout: valid, dst, src (5,0), payload.
    function automatic logic [48:0] mk_pkt(input logic [3:0] dl, input logic [3:0] dp,
                                           input logic [31:0] p);
        return {1'b1, dl, dp, 4'h5, 4'h0, p};
    endfunction

    always @(negedge clk) begin
        rdy_hist[cyc % 4096] = ready;
        if (vld && ack) begin
            acc_q.push_back(mk_pkt(dst_leaf, dst_port, din));
            acc_cyc.push_back(cyc);
        end
        if (dout[48] === 1'b1) begin
            got_q.push_back(dout);
            got_cyc.push_back(cyc);
        end else if (dout !== '0) begin
            nz_idle++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        acc_q.delete(); acc_cyc.delete(); got_q.delete(); got_cyc.delete();
        nz_idle = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; vld = 1'b0; resend = 1'b0; fsu = 1'b0;
        tick(2);
        reset = 1'b0;
        clear_obs();
    endtask

    task automatic push_word(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        vld = 1'b1;
        din = w;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ack === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
        vld = 1'b0;
    endtask

    function automatic int count_mismatch();
        int n = 0;
        for (int i = 0; i < got_q.size() && i < acc_q.size(); i++)
            if (got_q[i] !== acc_q[i]) n++;
        return n;
    endfunction

    task automatic test_reset();
        reset = 1'b1; vld = 1'b1; din = 32'h1234; ready = 1'b1;
        resend = 1'b0; fsu = 1'b0; dst_leaf = 4'h3; dst_port = 4'h1;
        @(negedge clk);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack_low: got %0b want 0", ack); end
        tick(1); tick(1);
        reset = 1'b0; vld = 1'b0;
        @(negedge clk);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL reset_ack_after: got %0b want 1", ack); end
        total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout: got %0h want 0", dout); end
        total++; if (dut.credit !== 8'd128) begin bad++; $display("FAIL reset_credit: got %0d want 128", dut.credit); end
        @(posedge clk); #1;
        clear_obs();
    endtask

    task automatic test_stream();
        bit ok, all_ok;
        dst_leaf = 4'h3; dst_port = 4'h1; ready = 1'b1;
        do_reset();
        all_ok = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push_word(32'(i), ok);
            all_ok &= ok;
        end
        tick(5);
        total++; if (!all_ok) begin bad++; $display("FAIL stream_accept: got timeout want accept"); end
        total++; if (got_q.size() != 5) begin bad++; $display("FAIL stream_count: got %0d want 5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== mk_pkt(4'h3, 4'h1, 32'(i + 1))) begin
                bad++; $display("FAIL stream_pkt%0d: got %0h want %0h", i, got_q[i], mk_pkt(4'h3, 4'h1, 32'(i + 1)));
            end
            total++;
            if (got_cyc[i] != acc_cyc[0] + 2 + i) begin
                bad++; $display("FAIL stream_time%0d: got %0d want %0d", i, got_cyc[i], acc_cyc[0] + 2 + i);
            end
        end
        total++; if (dut.credit !== 8'd123) begin bad++; $display("FAIL stream_credit: got %0d want 123", dut.credit); end
    endtask

    task automatic test_credit();
        bit ok, all_ok;
        int m;
        ready = 1'b1;
        do_reset();
        all_ok = 1'b1;
        for (int i = 0; i < 128; i++) begin
            push_word($urandom, ok);
            all_ok &= ok;
        end
        total++; if (!all_ok) begin bad++; $display("FAIL credit_accept: got timeout want accept"); end
        fork
            begin
                bit okf;
                for (int i = 0; i < 3; i++) push_word($urandom, okf);
            end
            begin
                for (int i = 0; i < 50 && acc_q.size() < 130; i++) tick(1);
                total++; if (acc_q.size() < 130) begin bad++; $display("FAIL credit_buffer2: got %0d want 130", acc_q.size()); end
                tick(3);
                @(negedge clk);
                total++; if (got_q.size() != 128) begin bad++; $display("FAIL credit_held: got %0d want 128", got_q.size()); end
                total++; if (ack !== 1'b0) begin bad++; $display("FAIL credit_ack_low: got %0b want 0", ack); end
                total++; if (dut.credit !== 8'd0) begin bad++; $display("FAIL credit_zero: got %0d want 0", dut.credit); end
                @(posedge clk); #1;
                fsu = 1'b1;
                m = cyc;
                tick(1);
                fsu = 1'b0;
                @(negedge clk);
                @(negedge clk);
                total++; if (dut.credit !== 8'd63) begin bad++; $display("FAIL credit_63: got %0d want 63", dut.credit); end
                tick(8);
            end
        join
        total++; if (got_q.size() != 131) begin bad++; $display("FAIL credit_total: got %0d want 131", got_q.size()); end
        total++;
        if (got_q.size() > 128 && got_cyc[128] != m + 2) begin
            bad++; $display("FAIL credit_release_time: got %0d want %0d", got_cyc[128], m + 2);
        end
        total++; if (count_mismatch() != 0) begin bad++; $display("FAIL credit_data: got %0d bad words want 0", count_mismatch()); end
        total++; if (dut.credit !== 8'd61) begin bad++; $display("FAIL credit_end: got %0d want 61", dut.credit); end
    endtask

    task automatic test_ready_low();
        int l, accepted, issued;
        ready = 1'b1;
        do_reset();
        fork
            begin
                bit ok;
                for (int i = 0; i < 12; i++) push_word($urandom, ok);
            end
            begin
                tick(4);
                ready = 1'b0;
                l = cyc;
                tick(9);
                @(negedge clk);
                total++; if (ack !== 1'b0) begin bad++; $display("FAIL rdylow_ack: got %0b want 0", ack); end
                @(posedge clk); #1;
                ready = 1'b1;
                @(negedge clk);
                total++; if (ack !== 1'b0) begin bad++; $display("FAIL rdylow_ack_pop: got %0b want 0", ack); end
                @(negedge clk);
                total++; if (ack !== 1'b1) begin bad++; $display("FAIL rdylow_ack_back: got %0b want 1", ack); end
            end
        join
        tick(6);
        issued = 0; accepted = 0;
        for (int i = 0; i < got_cyc.size(); i++) begin
            if (got_cyc[i] >= l + 1 && got_cyc[i] <= l + 10) issued += 1000;
            else if (got_cyc[i] <= l) issued++;
        end
        for (int i = 0; i < acc_cyc.size(); i++) if (acc_cyc[i] <= l + 9) accepted++;
        total++; if (issued >= 1000) begin bad++; $display("FAIL rdylow_quiet: got %0d outputs want 0", issued / 1000); end
        total++; if (accepted - (issued % 1000) != 2) begin bad++; $display("FAIL rdylow_absorb: got %0d want 2", accepted - (issued % 1000)); end
        total++; if (got_q.size() != 12) begin bad++; $display("FAIL rdylow_count: got %0d want 12", got_q.size()); end
        total++; if (count_mismatch() != 0) begin bad++; $display("FAIL rdylow_order: got %0d bad words want 0", count_mismatch()); end
    endtask

    task automatic test_resend();
        bit ok;
        int r, n;
        logic [31:0] x;
        ready = 1'b1; dst_leaf = 4'h3; dst_port = 4'h1;
        do_reset();
        push_word(32'hCAFEF00D, ok);
        tick(4);
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL resend_first: got %0d want 1", got_q.size()); end
        resend = 1'b1; r = cyc;
        tick(1);
        tick(1);
        resend = 1'b0;
        tick(6);
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL resend_once: got %0d want 2", got_q.size()); end
        total++;
        if (got_q.size() > 1 && got_q[1] !== mk_pkt(4'h3, 4'h1, 32'hCAFEF00D)) begin
            bad++; $display("FAIL resend_pkt: got %0h want %0h", got_q[1], mk_pkt(4'h3, 4'h1, 32'hCAFEF00D));
        end
        total++; if (got_q.size() > 1 && got_cyc[1] != r + 2) begin bad++; $display("FAIL resend_time: got %0d want %0d", got_cyc[1], r + 2); end
        total++; if (dut.credit !== 8'd127) begin bad++; $display("FAIL resend_credit: got %0d want 127", dut.credit); end
        x = $urandom;
        push_word(x, ok);
        n = acc_cyc[acc_cyc.size() - 1];
        resend = 1'b1;
        tick(1);
        resend = 1'b0;
        tick(5);
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL resend_same_count: got %0d want 4", got_q.size()); end
        if (got_q.size() == 4) begin
            total++;
            if (got_q[2] !== mk_pkt(4'h3, 4'h1, x) || got_q[3] !== mk_pkt(4'h3, 4'h1, x)) begin
                bad++; $display("FAIL resend_same_pkt: got %0h/%0h want %0h", got_q[2], got_q[3], mk_pkt(4'h3, 4'h1, x));
            end
            total++;
            if (got_cyc[2] != n + 2 || got_cyc[3] != n + 3) begin
                bad++; $display("FAIL resend_same_time: got %0d/%0d want %0d/%0d", got_cyc[2], got_cyc[3], n + 2, n + 3);
            end
        end
        total++; if (dut.credit !== 8'd126) begin bad++; $display("FAIL resend_same_credit: got %0d want 126", dut.credit); end
    endtask

    task automatic test_resend_after_reset();
        ready = 1'b1;
        do_reset();
        resend = 1'b1;
        tick(1);
        resend = 1'b0;
        tick(5);
        @(negedge clk);
        total++; if (got_q.size() != 0 || nz_idle != 0) begin bad++; $display("FAIL resend_noop: got %0d outputs want 0", got_q.size() + nz_idle); end
        total++; if (dout !== '0) begin bad++; $display("FAIL resend_noop_dout: got %0h want 0", dout); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit drv_done;
        int viol;
        do_reset();
        drv_done = 1'b0;
        fork
            begin
                bit ok;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) tick(1);
                    dst_leaf = 4'($urandom);
                    dst_port = 4'($urandom);
                    push_word($urandom, ok);
                end
                drv_done = 1'b1;
            end
            begin
                for (int g = 0; g < 2000 && !drv_done; g++) begin
                    ready = ($urandom_range(0, 9) < 7);
                    tick(1);
                end
            end
        join
        ready = 1'b1;
        tick(6);
        viol = 0;
        for (int i = 0; i < got_cyc.size(); i++)
            if (!rdy_hist[(got_cyc[i] - 1) % 4096]) viol++;
        total++; if (got_q.size() != 40) begin bad++; $display("FAIL random_count: got %0d want 40", got_q.size()); end
        total++; if (count_mismatch() != 0) begin bad++; $display("FAIL random_data: got %0d bad words want 0", count_mismatch()); end
        total++; if (viol != 0) begin bad++; $display("FAIL random_ready: got %0d issues without ready want 0", viol); end
        total++; if (dut.credit !== 8'd88) begin bad++; $display("FAIL random_credit: got %0d want 88", dut.credit); end
        total++; if (nz_idle != 0) begin bad++; $display("FAIL random_idle_zero: got %0d want 0", nz_idle); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ready = 1'b1; dst_leaf = 4'h3; dst_port = 4'h1;
        do_reset();
        for (int i = 0; i < 130; i++) push_word($urandom, ok);
        tick(3);
        @(negedge clk);
        total++; if (dut.credit !== 8'd0 || got_q.size() != 128) begin
            bad++; $display("FAIL rstmid_setup: got credit %0d/%0d pkts want 0/128", dut.credit, got_q.size());
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rstmid_ack: got %0b want 0", ack); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (dout !== '0 || ack !== 1'b0) begin bad++; $display("FAIL rstmid_next: got dout %0h ack %0b want 0/0", dout, ack); end
        @(posedge clk); #1;
        reset = 1'b0;
        clear_obs();
        @(negedge clk);
        total++; if (dut.credit !== 8'd128) begin bad++; $display("FAIL rstmid_credit: got %0d want 128", dut.credit); end
        tick(10);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL rstmid_flush: got %0d packets want 0", got_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_credit();
        test_ready_low();
        test_resend();
        test_resend_after_reset();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
